// File: rtl/multi_cycle_core.sv
// multi_cycle_core: multi-cycle RV32I-subset core. One ALU and one unified
// memory port are reused across several states per instruction.
//
// Memory handshake: mem_req is the request valid. While mem_req=1 the
// address, write enable and store data stay constant. The access completes
// on the rising edge where mem_ready=1. Read data is taken from mem_rdata in
// that same cycle. mem_ready has no meaning while mem_req=0.
module multi_cycle_core #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          REG_COUNT = 32
) (
    input  logic        clk,
    input  logic        rst,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic        retire,
    output logic [31:0] retire_pc,
    output logic        halted,
    output logic [3:0]  dbg_state
);

    localparam int RW = $clog2(REG_COUNT);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXEC_R   = 4'd6,
        EXEC_I   = 4'd7,
        ALUWB    = 4'd8,
        BRANCH   = 4'd9,
        JAL      = 4'd10,
        TRAP     = 4'd11
    } state_t;

    state_t      state, state_nx;
    logic [31:0] pc, old_pc, ir, a_q, b_q, alu_out, mdr, retire_pc_q;
    logic [31:0] rf [REG_COUNT];

    logic        rf_we;
    logic [31:0] rf_wdata;

    // Instruction fields
    logic [6:0]  opcode, funct7;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  funct3;
    assign opcode = ir[6:0];
    assign rd     = ir[11:7];
    assign funct3 = ir[14:12];
    assign rs1    = ir[19:15];
    assign rs2    = ir[24:20];
    assign funct7 = ir[31:25];

    logic [31:0] imm_i, imm_s, imm_b, imm_j;
    assign imm_i = {{20{ir[31]}}, ir[31:20]};
    assign imm_s = {{20{ir[31]}}, ir[31:25], ir[11:7]};
    assign imm_b = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
    assign imm_j = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};

    // x0 is hard-wired to zero regardless of what the array holds
    logic [31:0] rs1_val, rs2_val;
    assign rs1_val = (rs1 == 5'd0) ? 32'd0 : rf[rs1[RW-1:0]];
    assign rs2_val = (rs2 == 5'd0) ? 32'd0 : rf[rs2[RW-1:0]];

    // Effective address for lw/sw, also used for the alignment trap
    logic [31:0] mem_ea;
    assign mem_ea = a_q + ((opcode == 7'b0100011) ? imm_s : imm_i);

    // On RV32E only x0..x15 exist; any reference to x16..x31 is illegal
    function automatic logic reg_bad(input logic [4:0] r);
        return (REG_COUNT == 16) && r[4];
    endfunction

    // Shared ALU; alt selects sub / sra within the funct3 group
    function automatic logic [31:0] alu(input logic [2:0] f3, input logic alt,
                                        input logic [31:0] x, input logic [31:0] y);
        logic [31:0] r;
        case (f3)
            3'b000:  r = alt ? (x - y) : (x + y);
            3'b001:  r = x << y[4:0];
            3'b010:  r = {31'd0, $signed(x) < $signed(y)};
            3'b011:  r = {31'd0, x < y};
            3'b100:  r = x ^ y;
            3'b101:  r = alt ? 32'($signed(x) >>> y[4:0]) : (x >> y[4:0]);
            3'b110:  r = x | y;
            default: r = x & y;
        endcase
        return r;
    endfunction

    // Decode: classify the instruction in IR and flag illegal register use
    logic is_lw, is_sw, is_r, is_i, is_br, is_jal, regs_bad;
    always_comb begin
        is_lw  = 1'b0;
        is_sw  = 1'b0;
        is_r   = 1'b0;
        is_i   = 1'b0;
        is_br  = 1'b0;
        is_jal = 1'b0;
        case (opcode)
            7'b0000011: is_lw = (funct3 == 3'b010);
            7'b0100011: is_sw = (funct3 == 3'b010);
            7'b0110011: is_r  = (funct7 == 7'b0000000) ||
                                ((funct7 == 7'b0100000) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
            7'b0010011: begin
                case (funct3)
                    3'b001:  is_i = (funct7 == 7'b0000000);
                    3'b101:  is_i = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
                    default: is_i = 1'b1;
                endcase
            end
            7'b1100011: is_br  = (funct3 == 3'b000) || (funct3 == 3'b001);
            7'b1101111: is_jal = 1'b1;
            default: ;
        endcase
        regs_bad = ((is_lw || is_r || is_i || is_jal) && reg_bad(rd)) ||
                   ((is_lw || is_sw || is_r || is_i || is_br) && reg_bad(rs1)) ||
                   ((is_sw || is_r || is_br) && reg_bad(rs2));
    end

    // Next state, memory port, retire strobe and register write port
    always_comb begin
        state_nx  = state;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = 32'd0;
        mem_wdata = 32'd0;
        retire    = 1'b0;
        rf_we     = 1'b0;
        rf_wdata  = 32'd0;
        case (state)
            FETCH: begin
                mem_req  = 1'b1;
                mem_addr = pc;
                if (mem_ready) state_nx = DECODE;
            end
            DECODE: begin
                if (regs_bad)                 state_nx = TRAP;
                else if (is_lw || is_sw)      state_nx = MEMADR;
                else if (is_r)                state_nx = EXEC_R;
                else if (is_i)                state_nx = EXEC_I;
                else if (is_br)               state_nx = BRANCH;
                else if (is_jal)              state_nx = JAL;
                else                          state_nx = TRAP;
            end
            MEMADR: begin
                if (mem_ea[1:0] != 2'b00) state_nx = TRAP;
                else if (is_lw)           state_nx = MEMREAD;
                else                      state_nx = MEMWRITE;
            end
            MEMREAD: begin
                mem_req  = 1'b1;
                mem_addr = alu_out;
                if (mem_ready) state_nx = MEMWB;
            end
            MEMWB: begin
                rf_we    = 1'b1;
                rf_wdata = mdr;
                retire   = 1'b1;
                state_nx = FETCH;
            end
            MEMWRITE: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = alu_out;
                mem_wdata = b_q;
                if (mem_ready) begin
                    retire   = 1'b1;
                    state_nx = FETCH;
                end
            end
            EXEC_R, EXEC_I: state_nx = ALUWB;
            ALUWB: begin
                rf_we    = 1'b1;
                rf_wdata = alu_out;
                retire   = 1'b1;
                state_nx = FETCH;
            end
            BRANCH: begin
                retire   = 1'b1;
                state_nx = FETCH;
            end
            JAL: begin
                rf_we    = 1'b1;
                rf_wdata = old_pc + 32'd4;
                retire   = 1'b1;
                state_nx = FETCH;
            end
            default: state_nx = TRAP;
        endcase
        // Keep the port quiet while reset is held even though state is FETCH
        if (!rst) begin
            mem_req   = 1'b0;
            mem_we    = 1'b0;
            mem_addr  = 32'd0;
            mem_wdata = 32'd0;
            retire    = 1'b0;
            rf_we     = 1'b0;
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= FETCH;
        else      state <= state_nx;
    end

    // Datapath registers: PC, OldPC, IR, A, B, ALUOut, MDR
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc      <= RESET_PC;
            old_pc  <= 32'd0;
            ir      <= 32'd0;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            alu_out <= 32'd0;
            mdr     <= 32'd0;
        end else begin
            case (state)
                FETCH: if (mem_ready) begin
                    ir     <= mem_rdata;
                    old_pc <= pc;
                    pc     <= pc + 32'd4;
                end
                DECODE: begin
                    a_q     <= rs1_val;
                    b_q     <= rs2_val;
                    alu_out <= old_pc + imm_b;
                end
                MEMADR:  alu_out <= mem_ea;
                MEMREAD: if (mem_ready) mdr <= mem_rdata;
                EXEC_R:  alu_out <= alu(funct3, ir[30], a_q, b_q);
                EXEC_I:  alu_out <= alu(funct3, (funct3 == 3'b101) && ir[30], a_q, imm_i);
                BRANCH:  if ((a_q == b_q) ^ (funct3 == 3'b001)) pc <= alu_out;
                JAL:     pc <= old_pc + imm_j;
                default: ;
            endcase
        end
    end

    // Register file write port; writes to x0 are dropped
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < REG_COUNT; i++) rf[i] <= 32'd0;
        end else if (rf_we && (rd != 5'd0)) begin
            rf[rd[RW-1:0]] <= rf_wdata;
        end
    end

    // Retire PC holds the last retired instruction's PC between retires
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)        retire_pc_q <= 32'd0;
        else if (retire) retire_pc_q <= old_pc;
    end

    assign retire_pc = retire ? old_pc : retire_pc_q;
    assign halted    = (state == TRAP);
    assign dbg_state = state;

endmodule

// File: tb/tb_multi_cycle_core.sv
// tb_multi_cycle_core: directed programs for multi_cycle_core with a memory
// model that inserts a configurable number of wait states per access.
module tb_multi_cycle_core;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic rst_e = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- main DUT (RV32I, RESET_PC=0x100) ----------------
    logic        mem_req, mem_we, mem_ready, retire, halted;
    logic [31:0] mem_addr, mem_wdata, mem_rdata, retire_pc;
    logic [3:0]  dbg_state;

    multi_cycle_core #(.RESET_PC(32'h100), .REG_COUNT(32)) u_dut (
        .clk(clk), .rst(rst),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .retire(retire), .retire_pc(retire_pc), .halted(halted),
        .dbg_state(dbg_state)
    );

    // ---------------- second DUT (RV32E, RESET_PC=0) ----------------
    logic        e_req, e_we, e_ready, e_retire, e_halted;
    logic [31:0] e_addr, e_wdata, e_rdata, e_retire_pc;
    logic [3:0]  e_state;

    multi_cycle_core #(.RESET_PC(32'h0), .REG_COUNT(16)) u_dut_e (
        .clk(clk), .rst(rst_e),
        .mem_req(e_req), .mem_we(e_we), .mem_addr(e_addr),
        .mem_wdata(e_wdata), .mem_rdata(e_rdata), .mem_ready(e_ready),
        .retire(e_retire), .retire_pc(e_retire_pc), .halted(e_halted),
        .dbg_state(e_state)
    );

    // ---------------- memory models ----------------
    logic [31:0] imem [1024];
    logic [31:0] dmem [1024];
    logic        dvalid [1024];
    logic [31:0] imem_e [64];
    int waits = 0;
    int wcnt;

    assign mem_ready = mem_req && (wcnt >= waits);
    assign mem_rdata = dvalid[mem_addr[11:2]] ? dmem[mem_addr[11:2]] : imem[mem_addr[11:2]];
    assign e_ready   = e_req;
    assign e_rdata   = imem_e[e_addr[7:2]];

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            wcnt <= 0;
            for (int i = 0; i < 1024; i++) dvalid[i] <= 1'b0;
        end else begin
            if (mem_req && !mem_ready) wcnt <= wcnt + 1;
            else                       wcnt <= 0;
            if (mem_req && mem_ready && mem_we) begin
                dmem[mem_addr[11:2]]   <= mem_wdata;
                dvalid[mem_addr[11:2]] <= 1'b1;
            end
        end
    end

    // ---------------- scoreboard ----------------
    int n_vec = 0;
    int n_err = 0;
    logic [63:0] exp_ret_q[$];   // {gap cycles (0 = unchecked), retire pc}
    logic [63:0] exp_wr_q[$];    // {address, data}
    logic [31:0] exp_e_q[$];     // retire pcs of the RV32E core
    logic [63:0] ret_e, wr_e;
    int last_ret_cyc = 0;
    logic [31:0] prog_pc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic miss(input string name, input logic [31:0] act);
        n_vec++;
        n_err++;
        $display("FAIL %s: got %h, want no event", name, act);
    endtask

    // Monitor for the main core: retire order/latency, store traffic, trap quiet
    always @(negedge clk) begin
        if (rst) begin
            if (retire) begin
                if (exp_ret_q.size() == 0) miss("retire_pc", retire_pc);
                else begin
                    ret_e = exp_ret_q.pop_front();
                    chk("retire_pc", retire_pc, ret_e[31:0]);
                    if (ret_e[63:32] != 32'd0) chk("retire_gap", cyc - last_ret_cyc, ret_e[63:32]);
                end
                last_ret_cyc = cyc;
            end
            if (mem_req && mem_we) begin
                if (exp_wr_q.size() == 0) miss("wr_addr", mem_addr);
                else begin
                    wr_e = exp_wr_q[0];
                    chk("wr_addr", mem_addr, wr_e[63:32]);
                    chk("wr_data", mem_wdata, wr_e[31:0]);
                    if (mem_ready) void'(exp_wr_q.pop_front());
                end
            end
            if (halted && (mem_req || retire)) miss("halted_activity", {30'd0, mem_req, retire});
        end
    end

    // Monitor for the RV32E core
    always @(negedge clk) begin
        if (rst_e) begin
            if (e_retire) begin
                if (exp_e_q.size() == 0) miss("e_retire_pc", e_retire_pc);
                else chk("e_retire_pc", e_retire_pc, exp_e_q.pop_front());
            end
            if (e_req && e_we) miss("e_write", e_wdata);
        end
    end

    // ---------------- instruction encoders ----------------
    function automatic logic [31:0] enc_r(input int f7, input int rs2, input int rs1, input int f3, input int rd);
        return {7'(f7), 5'(rs2), 5'(rs1), 3'(f3), 5'(rd), 7'h33};
    endfunction

    function automatic logic [31:0] enc_i(input int imm, input int rs1, input int f3, input int rd, input int op);
        logic [31:0] im;
        im = imm;
        return {im[11:0], 5'(rs1), 3'(f3), 5'(rd), 7'(op)};
    endfunction

    function automatic logic [31:0] enc_s(input int imm, input int rs2, input int rs1);
        logic [31:0] im;
        im = imm;
        return {im[11:5], 5'(rs2), 5'(rs1), 3'b010, im[4:0], 7'h23};
    endfunction

    function automatic logic [31:0] enc_b(input int imm, input int rs2, input int rs1, input int f3);
        logic [31:0] im;
        im = imm;
        return {im[12], im[10:5], 5'(rs2), 5'(rs1), 3'(f3), im[4:1], im[11], 7'h63};
    endfunction

    function automatic logic [31:0] enc_j(input int imm, input int rd);
        logic [31:0] im;
        im = imm;
        return {im[20], im[10:1], im[11], im[19:12], 5'(rd), 7'h6F};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic new_prog();
        for (int i = 0; i < 1024; i++) imem[i] = 32'd0;
        prog_pc = 32'h100;
    endtask

    task automatic put(input logic [31:0] w);
        imem[prog_pc[11:2]] = w;
        prog_pc = prog_pc + 32'd4;
    endtask

    task automatic exp_ret(input logic [31:0] pc, input int gap);
        exp_ret_q.push_back({32'(gap), pc});
    endtask

    task automatic put_ret(input logic [31:0] w, input int gap);
        exp_ret(prog_pc, gap);
        put(w);
    endtask

    task automatic exp_wr(input logic [31:0] addr, input logic [31:0] data);
        exp_wr_q.push_back({addr, data});
    endtask

    // Reset the core, check reset and first-fetch state, run to the trap
    task automatic run(input int w);
        int n;
        waits = w;
        @(negedge clk); #2 rst = 1'b0;
        #1;
        chk("rst_halted", {31'd0, halted}, 32'd0);
        chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_retire", {31'd0, retire}, 32'd0);
        chk("rst_state", {28'd0, dbg_state}, 32'd0);
        @(negedge clk); #2 rst = 1'b1;
        #1;
        chk("first_req", {31'd0, mem_req}, 32'd1);
        chk("first_addr", mem_addr, 32'h100);
        chk("first_we", {31'd0, mem_we}, 32'd0);
        n = 0;
        while (!halted && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (!halted) miss("halt_timeout", {28'd0, dbg_state});
        repeat (5) @(negedge clk);
        chk("halted", {31'd0, halted}, 32'd1);
        chk("retires_left", exp_ret_q.size(), 32'd0);
        chk("writes_left", exp_wr_q.size(), 32'd0);
        exp_ret_q.delete();
        exp_wr_q.delete();
    endtask

    // ---------------- stimulus ----------------
    int          st_reg [19] = '{0, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15, 16, 17, 18, 19, 20};
    logic [31:0] st_val [19] = '{32'h0, 32'h2, 32'h0, 32'h8, 32'h1, 32'hFFFF_FFF8, 32'hA0,
                                 32'h07FF_FFFF, 32'hFFFF_FFFF, 32'h5, 32'hFFFF_FFFD, 32'd40,
                                 32'hF, 32'hFFFF_FFFE, 32'hF0, 32'hFFFF_FFF5, 32'hFFFF_FFFA,
                                 32'h1, 32'h1};
    logic [31:0] w0;

    initial begin
        // Phase A: ALU set, zero wait states; results stored to 0x400+
        new_prog();
        put_ret(enc_i(5, 0, 0, 1, 7'h13), 0);        // addi x1,x0,5
        put_ret(enc_i(-3, 0, 0, 2, 7'h13), 4);       // addi x2,x0,-3
        put_ret(enc_r(0, 2, 1, 0, 3), 4);            // add  x3,x1,x2
        put_ret(enc_r(0, 1, 2, 3, 4), 4);            // sltu x4,x2,x1
        put_ret(enc_r(32, 2, 1, 0, 5), 4);           // sub  x5,x1,x2
        put_ret(enc_r(0, 1, 2, 2, 6), 4);            // slt  x6,x2,x1
        put_ret(enc_r(0, 2, 1, 4, 7), 4);            // xor  x7,x1,x2
        put_ret(enc_r(0, 1, 1, 1, 8), 4);            // sll  x8,x1,x1
        put_ret(enc_r(0, 1, 2, 5, 9), 4);            // srl  x9,x2,x1
        put_ret(enc_r(32, 1, 2, 5, 10), 4);          // sra  x10,x2,x1
        put_ret(enc_r(0, 2, 1, 7, 11), 4);           // and  x11,x1,x2
        put_ret(enc_r(0, 2, 1, 6, 12), 4);           // or   x12,x1,x2
        put_ret(enc_i(3, 1, 1, 13, 7'h13), 4);       // slli x13,x1,3
        put_ret(enc_i(28, 2, 5, 14, 7'h13), 4);      // srli x14,x2,28
        put_ret(enc_i(12'h401, 2, 5, 15, 7'h13), 4); // srai x15,x2,1
        put_ret(enc_i(12'hF0, 2, 7, 16, 7'h13), 4);  // andi x16,x2,0xF0
        put_ret(enc_i(-16, 1, 6, 17, 7'h13), 4);     // ori  x17,x1,-16
        put_ret(enc_i(-1, 1, 4, 18, 7'h13), 4);      // xori x18,x1,-1
        put_ret(enc_i(-2, 2, 2, 19, 7'h13), 4);      // slti x19,x2,-2
        put_ret(enc_i(-1, 1, 3, 20, 7'h13), 4);      // sltiu x20,x1,-1
        put_ret(enc_i(7, 0, 0, 0, 7'h13), 4);        // addi x0,x0,7
        put_ret(enc_i(1024, 0, 0, 21, 7'h13), 4);    // addi x21,x0,1024
        for (int k = 0; k < 19; k++) begin
            put_ret(enc_s(4 * k, st_reg[k], 21), 4);
            exp_wr(32'h400 + 32'(4 * k), st_val[k]);
        end
        run(0);

        // Phase B: branches and jumps, zero wait states
        new_prog();
        put(enc_i(1, 0, 0, 1, 7'h13));               // 100 addi x1,x0,1
        put(enc_b(8, 1, 1, 0));                      // 104 beq x1,x1,+8
        put(enc_i(99, 2, 0, 2, 7'h13));              // 108 skipped
        put(enc_b(8, 1, 1, 1));                      // 10C bne x1,x1,+8
        put(enc_j(16, 5));                           // 110 jal x5,+16
        put(enc_i(99, 2, 0, 2, 7'h13));              // 114 skipped
        put(enc_i(99, 2, 0, 2, 7'h13));              // 118 skipped
        put(enc_i(99, 2, 0, 2, 7'h13));              // 11C skipped
        put(enc_b(8, 0, 1, 0));                      // 120 beq x1,x0,+8
        put(enc_b(12, 0, 1, 1));                     // 124 bne x1,x0,+12
        put(enc_i(99, 2, 0, 2, 7'h13));              // 128 skipped
        put(enc_i(99, 2, 0, 2, 7'h13));              // 12C skipped
        put(enc_s(32'h40, 5, 0));                    // 130 sw x5,0x40(x0)
        put(enc_j(12, 6));                           // 134 jal x6,+12
        put(enc_s(32'h44, 6, 0));                    // 138 sw x6,0x44(x0)
        put(enc_j(16, 0));                           // 13C jal x0,+16
        put(enc_j(-8, 7));                           // 140 jal x7,-8
        put(enc_i(99, 2, 0, 2, 7'h13));              // 144 skipped
        put(enc_i(99, 2, 0, 2, 7'h13));              // 148 skipped
        put(enc_s(32'h48, 7, 0));                    // 14C sw x7,0x48(x0)
        exp_ret(32'h100, 0); exp_ret(32'h104, 3); exp_ret(32'h10C, 3);
        exp_ret(32'h110, 3); exp_ret(32'h120, 3); exp_ret(32'h124, 3);
        exp_ret(32'h130, 4); exp_ret(32'h134, 3); exp_ret(32'h140, 3);
        exp_ret(32'h138, 4); exp_ret(32'h13C, 3); exp_ret(32'h14C, 4);
        exp_wr(32'h40, 32'h114);
        exp_wr(32'h44, 32'h138);
        exp_wr(32'h48, 32'h144);
        run(0);

        // Phase C: sw/lw with two wait states on every access
        new_prog();
        w0 = enc_i(2, 0, 0, 3, 7'h13);
        put_ret(w0, 0);                              // addi x3,x0,2
        put_ret(enc_s(8, 3, 0), 8);                  // sw x3,8(x0)
        put_ret(enc_i(8, 0, 2, 5, 7'h03), 9);        // lw x5,8(x0)
        put_ret(enc_s(32'h10, 5, 0), 8);             // sw x5,0x10(x0)
        put_ret(enc_i(32'h100, 0, 2, 6, 7'h03), 9);  // lw x6,0x100(x0)
        put_ret(enc_s(32'h14, 6, 0), 8);             // sw x6,0x14(x0)
        exp_wr(32'h8, 32'h2);
        exp_wr(32'h10, 32'h2);
        exp_wr(32'h14, w0);
        run(2);

        // Phase D: misaligned lw traps before any memory access
        new_prog();
        put_ret(enc_i(4, 0, 0, 1, 7'h13), 0);        // addi x1,x0,4
        put(enc_i(6, 0, 2, 2, 7'h03));               // lw x2,6(x0)
        run(1);

        // Phase E: illegal opcode 1111111 traps without retiring
        new_prog();
        put(32'h0000_007F);
        run(0);

        // Phase F: after a trap, reset restarts cleanly; x0 stays zero
        new_prog();
        put_ret(enc_i(7, 0, 0, 0, 7'h13), 0);        // addi x0,x0,7
        put_ret(enc_s(32'h20, 0, 0), 4);             // sw x0,0x20(x0)
        exp_wr(32'h20, 32'h0);
        run(0);

        // RV32E core: reference to x17 traps
        for (int i = 0; i < 64; i++) imem_e[i] = 32'd0;
        imem_e[0] = enc_i(1, 0, 0, 1, 7'h13);        // addi x1,x0,1
        imem_e[1] = enc_i(2, 1, 0, 15, 7'h13);       // addi x15,x1,2
        imem_e[2] = enc_r(0, 2, 1, 0, 17);           // add x17,x1,x2
        exp_e_q.push_back(32'h0);
        exp_e_q.push_back(32'h4);
        @(negedge clk); #2 rst_e = 1'b1;
        for (int n = 0; n < 200 && !e_halted; n++) @(negedge clk);
        repeat (3) @(negedge clk);
        chk("e_halted", {31'd0, e_halted}, 32'd1);
        chk("e_state", {28'd0, e_state}, 32'd11);
        chk("e_retires_left", exp_e_q.size(), 32'd0);
        chk("e_retire_pc_hold", e_retire_pc, 32'h4);
        chk("e_mem_req", {31'd0, e_req}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/multi_cycle_core.md
# multi_cycle_core

Multi-cycle RV32I-subset processor core, the successor to the team's single-cycle core. It reuses one ALU and one unified memory port across several cycles per instruction under a state machine. It talks to an external instruction/data memory through a request/ready handshake with arbitrary wait states. It adds bne, the full shift/compare/xor ALU set, trap-on-illegal and a retire strobe for verification.

## Interface
- RESET_PC, 32'h0000_0000: PC value loaded on reset.
- REG_COUNT, 32: architectural registers. Legal values are 32 (RV32I) and 16 (RV32E). With 16, a register index ≥16 traps.
- clk  in  1  core clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-low; asserting it clears all state immediately.
- mem_req  out  1  memory request valid.
- mem_we  out  1  1 = write (sw), 0 = read.
- mem_addr  out  32  byte address, always word-aligned.
- mem_wdata  out  32  store data.
- mem_rdata  in  32  read data, valid in the cycle mem_ready=1.
- mem_ready  in  1  request accepted/completed this cycle.
- retire  out  1  one-cycle pulse when an instruction completes.
- retire_pc  out  32  PC of the retiring instruction.
- halted  out  1  sticky trap indicator.

## Operation
- Supported instructions:
  - lw and sw (word only).
  - R-type add, sub, and, or, xor, slt, sltu, sll, srl, sra.
  - I-type addi, andi, ori, xori, slti, sltiu, slli, srli, srai.
  - beq, bne, jal.
- Any other opcode or funct combination is illegal.
- Internal registers: PC, OldPC, IR, A, B, ALUOut, MDR, and a register file of REG_COUNT×32.
  - x0 reads 0; writes to x0 are discarded.
- Immediates: I, S, B and J formats, sign-extended from bit 31. B and J offsets have bit 0 = 0.
- ALU arithmetic is 32-bit modulo 2^32 with no overflow flag.
  - slt is signed; sltu is unsigned.
  - Shift amount is B[4:0]; sra replicates bit 31.
- State machine:
  - FETCH: mem_req=1, mem_we=0, mem_addr=PC. Hold until mem_ready=1. On that edge: IR<=mem_rdata, OldPC<=PC, PC<=PC+4, go to DECODE.
  - DECODE: A<=rs1, B<=rs2, ALUOut<=OldPC+immB. Next state by opcode:
    - lw/sw → MEMADR
    - R-type → EXEC_R
    - I-type → EXEC_I
    - beq/bne → BRANCH
    - jal → JAL
    - otherwise → TRAP
  - MEMADR: ALUOut<=A+imm (I-format for lw, S-format for sw). If the address has bits [1:0]≠0 → TRAP; else lw → MEMREAD, sw → MEMWRITE.
  - MEMREAD: mem_req=1, mem_addr=ALUOut. On mem_ready: MDR<=mem_rdata → MEMWB.
  - MEMWB: rd<=MDR, retire, → FETCH.
  - MEMWRITE: mem_req=1, mem_we=1, mem_wdata=B. On mem_ready: retire, → FETCH.
  - EXEC_R / EXEC_I: ALUOut<=A op B / A op imm → ALUWB.
  - ALUWB: rd<=ALUOut, retire, → FETCH.
  - BRANCH: if (A==B) xor (funct3==001), then PC<=ALUOut. Retire, → FETCH.
  - JAL: rd<=OldPC+4, PC<=OldPC+immJ, retire, → FETCH.
  - TRAP: halted=1, mem_req=0, no retire. Stays until reset.
- mem_addr, mem_we and mem_wdata stay stable while mem_req=1 and mem_ready=0.

## Timing
- Reset values (rst=0, asynchronous):
  - state=FETCH, PC=RESET_PC, OldPC/IR/A/B/ALUOut/MDR=0, all registers=0.
  - mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, retire=0, retire_pc=0, halted=0.
- First request: mem_req rises combinationally in FETCH on the first clock after rst deasserts. A mid-transaction reset aborts the access; no register or PC update occurs.
- Zero-wait latencies (cycles from start of FETCH to retire, inclusive):
  - lw: 5
  - sw: 4
  - R-type: 4
  - I-type: 4
  - beq/bne: 3
  - jal: 3
- Each wait state (mem_ready=0 while mem_req=1) adds exactly one cycle to FETCH, MEMREAD or MEMWRITE.
- mem_ready is ignored while mem_req=0.
- retire is high for exactly the one cycle of the final state. retire_pc=OldPC in that cycle; retire_pc holds its value otherwise.
- PC wraps modulo 2^32.
- A write to rd and a read of the same register in the following instruction's DECODE return the new value (no hazards, by construction).

## Test plan
- Reset with RESET_PC=32'h100, release rst, mem_ready=1 → first mem_addr=0x100, mem_req=1 in the first cycle. halted=0.
- addi x1,x0,5 ; addi x2,x0,-3 ; add x3,x1,x2 ; sltu x4,x2,x1 → x3=2, x4=0. Four retire pulses with retire_pc 0,4,8,12.
- sw x3,8(x0) then lw x5,8(x0) with 2 wait states on every access → write to address 8, data 2. x5=2. The lw retires 9 cycles after its FETCH begins. Address and data are held stable through the wait states.
- beq x1,x1,+8 at PC 0x20 → next fetch 0x28. bne x1,x1,+8 → next fetch 0x24. jal x1,-16 at 0x40 → x1=0x44, next fetch 0x30.
- Opcode 7'b1111111, or lw from address 0x6 → halted=1, no further mem_req, no retire. rst low → halted=0, PC=RESET_PC.
- addi x0,x0,7 → x0 still reads 0. With REG_COUNT=16, add x17,x1,x2 → TRAP.
